if_fetch_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the core's decode/register-read stage.
- Owns the fetch PC and issues word-aligned read requests to instruction memory, which may have variable latency.
- Buffers returned instructions with their PCs in a small prefetch queue and presents them to decode through a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes the queue and discards any in-flight response.

---
 rtl/if_fetch_unit_pkg.sv | 15 +
 rtl/if_fifo.sv | 52 +++++
 rtl/if_fetch_unit.sv | 104 ++++++++++
 tb/tb_if_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared constants and FSM encoding for the instruction-fetch front end
package if_fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;
    // byte-offset bits that must be cleared to word-align a PC
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous FIFO with flush; push while full is accepted only alongside a pop
module if_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;

    assign full    = count == (AW + 1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // pointers and occupancy; flush empties the queue in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    // storage needs no reset: the head is only meaningful when not empty
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the fetch PC, sequences single-outstanding imem reads and feeds decode from a prefetch queue
module if_fetch_unit #(
    parameter int              XLEN     = if_fetch_unit_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
);

    import if_fetch_unit_pkg::*;

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [XLEN-1:0] RST_PC  = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_e      state, next_state;
    logic [XLEN-1:0]   fetch_pc, req_pc, last_pc, head_pc, head_inst;
    logic [2*XLEN-1:0] head;
    logic [CW-1:0]     count;
    logic [CW:0]       next_count;
    logic              full, empty, push, pop, issue;

    assign pop        = !empty && inst_ready_i;
    assign push       = (state == WAIT) && imem_rvalid_i && !redirect_i;
    assign next_count = {1'b0, count} + (CW + 1)'(push) - (CW + 1)'(pop);
    assign head_pc    = head[2*XLEN-1:XLEN];
    assign head_inst  = head[XLEN-1:0];

    // the request is combinational so a 1-cycle memory sustains one fetch per cycle;
    // gating with reset keeps the bus quiet while reset is held
    assign imem_req_o   = issue && rst_i;
    assign imem_addr_o  = fetch_pc;
    assign inst_valid_o = !empty;
    assign inst_o       = empty ? XLEN'(NOP) : head_inst;
    assign inst_pc_o    = empty ? last_pc : head_pc;

    if_fifo #(
        .W     (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_i),
        .flush (redirect_i),
        .push  (push),
        .pop   (pop),
        .din   ({req_pc, imem_rdata_i}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // next state and request issue; a redirect overrides push, pop and issue
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        case (state)
            FETCH: begin
                issue      = !full;
                next_state = full ? FETCH : WAIT;
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    issue      = next_count < {1'b0, DEPTH_C};
                    next_state = issue ? WAIT : FETCH;
                end
            end
            DISCARD: next_state = imem_rvalid_i ? FETCH : DISCARD;
            default: next_state = FETCH;
        endcase
        if (redirect_i) begin
            issue      = 1'b0;
            next_state = (state != FETCH && !imem_rvalid_i) ? DISCARD : FETCH;
        end
    end

    // FSM state, fetch PC, PC of the in-flight request and the last head PC shown to decode
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= FETCH;
            fetch_pc <= RST_PC;
            req_pc   <= '0;
            last_pc  <= '0;
        end else begin
            state <= next_state;
            if (redirect_i) fetch_pc <= {redirect_pc_i[XLEN-1:2], redirect_pc_i[1:0] & ~ALIGN_MASK};
            else if (issue) fetch_pc <= fetch_pc + XLEN'(4);
            if (issue) req_pc <= fetch_pc;
            if (!empty) last_pc <= head_pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and randomized checks of the fetch unit against a queue-based reference model
module tb_if_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i = 1'b0;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] mq[$];
    int          epoch = 0;
    int          mem_epoch = 0;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    logic [31:0] exp_req = '0;
    logic [31:0] last_pc = '0;
    int          lat = 1;
    logic        late_inject = 1'b0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;

    if_fetch_unit #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_req", imem_req_o, 0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_valid", inst_valid_o, 0);
        check("rst_inst", inst_o, NOP);
        check("rst_pc", inst_pc_o, 32'h0);
    endtask

    task automatic model_reset();
        mq.delete();
        mem_busy = 1'b0;
        epoch++;
        exp_req = 32'h0;
        last_pc = 32'h0;
    endtask

    // called just after a rising edge; leaves reset released just after the next rising edge
    task automatic do_reset();
        rst_i = 1'b0;
        redirect_i = 1'b0;
        imem_rvalid_i = 1'b0;
        inst_ready_i = 1'b0;
        model_reset();
        #1;
        check_reset_vals();
        @(posedge clk); #1;
        check_reset_vals();
        rst_i = 1'b1;
    endtask

    // one clock cycle: drive inputs, act as memory, sample mid-cycle, update the reference model
    task automatic cycle(input logic rd, input logic [31:0] rpc, input logic rdy);
        logic        ok;
        logic [31:0] resp_pc;
        ok = 1'b0;
        resp_pc = mem_addr;
        redirect_i = rd;
        redirect_pc_i = rpc;
        inst_ready_i = rdy;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = $urandom;
        if (late_inject) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i = 32'hDEAD_BEEF;
            late_inject = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i = memf(mem_addr);
                mem_busy = 1'b0;
                ok = (mem_epoch == epoch) && !rd;
            end
        end
        #4;
        s_req = imem_req_o;
        s_addr = imem_addr_o;
        s_valid = inst_valid_o;
        s_pc = inst_pc_o;
        s_inst = inst_o;
        if (mq.size() != 0) begin
            check("inst_valid", inst_valid_o, 1);
            check("inst_pc", inst_pc_o, mq[0]);
            check("inst", inst_o, memf(mq[0]));
            last_pc = mq[0];
        end else begin
            check("inst_valid", inst_valid_o, 0);
            check("inst_nop", inst_o, NOP);
            check("inst_pc_hold", inst_pc_o, last_pc);
        end
        if (imem_req_o) begin
            check("one_outstanding", mem_busy, 0);
            check("no_req_on_redirect", rd, 0);
            check("req_addr", imem_addr_o, exp_req);
        end
        if (rd) begin
            mq.delete();
            epoch++;
            exp_req = {rpc[31:2], 2'b00};
        end else begin
            if (rdy && mq.size() != 0) void'(mq.pop_front());
            if (ok) mq.push_back(resp_pc);
        end
        if (imem_req_o) begin
            check("space", mq.size() < DEPTH, 1);
            mem_busy = 1'b1;
            if (lat == 0) mem_cnt = int'($urandom_range(1, 3));
            else mem_cnt = lat;
            mem_addr = exp_req;
            mem_epoch = epoch;
            exp_req = exp_req + 32'd4;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic hit;
        @(posedge clk); #1;

        // streaming with 1-cycle memory and decode always ready
        lat = 1;
        do_reset();
        cycle(0, 0, 1);
        check("t1_req0", s_req, 1); check("t1_addr0", s_addr, 32'h0); check("t1_valid0", s_valid, 0);
        cycle(0, 0, 1);
        check("t1_req1", s_req, 1); check("t1_addr1", s_addr, 32'h4); check("t1_valid1", s_valid, 0);
        cycle(0, 0, 1);
        check("t1_valid2", s_valid, 1); check("t1_pc2", s_pc, 32'h0);
        check("t1_inst2", s_inst, memf(32'h0)); check("t1_addr2", s_addr, 32'h8);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1);
            check("t1_stream_valid", s_valid, 1);
            check("t1_stream_req", s_req, 1);
            check("t1_stream_pc", s_pc, 32'(4 * (i + 1)));
        end

        // backpressure fills exactly DEPTH entries, then drain resumes fetching at 0x10
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0);
            if (i >= 4) check("t2_req_full", s_req, 0);
        end
        check("t2_valid", s_valid, 1);
        cycle(0, 0, 1);
        check("t2_pc0", s_pc, 32'h0); check("t2_noreq", s_req, 0);
        cycle(0, 0, 1);
        check("t2_pc4", s_pc, 32'h4); check("t2_req10", s_req, 1); check("t2_addr10", s_addr, 32'h10);
        cycle(0, 0, 1);
        check("t2_pc8", s_pc, 32'h8);
        cycle(0, 0, 1);
        check("t2_pcc", s_pc, 32'hC);

        // latency 3, redirect one cycle after the request to 0x8
        lat = 3;
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 1);
            if (s_req && s_addr == 32'h8) begin hit = 1'b1; break; end
        end
        check("t3_saw_req8", hit, 1);
        cycle(1, 32'h100, 1);
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 1);
            if (s_req) begin hit = 1'b1; break; end
        end
        check("t3_req_after_redirect", hit, 1);
        check("t3_addr100", s_addr, 32'h100);
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 1);
            if (s_valid) begin hit = 1'b1; break; end
        end
        check("t3_delivered", hit, 1);
        check("t3_first_pc", s_pc, 32'h100);

        // redirect coinciding with rvalid, unaligned target
        lat = 2;
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_busy && mem_cnt == 1) begin
                cycle(1, 32'h103, 1);
                hit = 1'b1;
                break;
            end
            cycle(0, 0, 1);
        end
        check("t4_redirect_on_rvalid", hit, 1);
        cycle(0, 0, 1);
        check("t4_req", s_req, 1); check("t4_addr", s_addr, 32'h100);

        // PC wraps modulo 2^32
        lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);
        cycle(1, 32'hFFFF_FFF8, 1);
        cycle(0, 0, 1);
        check("t5_req0", s_req, 1); check("t5_addr0", s_addr, 32'hFFFF_FFF8);
        cycle(0, 0, 1);
        check("t5_addr1", s_addr, 32'hFFFF_FFFC);
        cycle(0, 0, 1);
        check("t5_addr2", s_addr, 32'h0000_0000);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);

        // asynchronous reset while waiting with the queue half full
        lat = 3;
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle(0, 0, 0);
            if (mq.size() == 2 && mem_busy) begin hit = 1'b1; break; end
        end
        check("t6_half_full", hit, 1);
        #2;
        rst_i = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        @(posedge clk); #1;
        rst_i = 1'b1;
        late_inject = 1'b1;
        cycle(0, 0, 1);
        check("t6_req", s_req, 1); check("t6_addr", s_addr, 32'h0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1);

        // randomized traffic: random latency, backpressure and redirects
        lat = 0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic        rd;
            logic [31:0] rpc;
            rd = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            cycle(rd, rpc, $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
